// File: rtl/serial_adder_pkg.sv
// Shared constants and state encoding for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned SA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder used as the only arithmetic element of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    logic half_sum;

    assign half_sum  = a ^ b;
    assign sum       = half_sum ^ carry_in;
    assign carry_out = (a & b) | (carry_in & half_sum);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit per cycle, LSB first, valid/ready handshakes.
//   state | meaning
//   IDLE  | in_ready high, waiting for operands
//   RUN   | adding one bit per cycle, WIDTH cycles in total
//   DONE  | result presented, held until the consumer takes it
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = SA_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fa_sum;
    logic             fa_carry;

    full_adder u_fa (
        .a         (a_sh_q[0]),
        .b         (b_sh_q[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_carry)
    );

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        sum_sh_d    = sum_sh_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = carry_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                carry_d  = fa_carry;
                cnt_d    = cnt_q + CNT_W'(1);
                // Output registers are loaded on the final bit so they hold while the next op runs.
                if (cnt_q == LAST_CNT) begin
                    sum_d       = sum_sh_d;
                    cout_d      = fa_carry;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance plus a 1-bit instance.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       carry_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       carry_out;

    logic       w1_in_valid;
    logic       w1_in_ready;
    logic [0:0] w1_a;
    logic [0:0] w1_b;
    logic       w1_carry_in;
    logic       w1_out_valid;
    logic       w1_out_ready;
    logic [0:0] w1_sum;
    logic       w1_carry_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w1_in_valid),
        .in_ready  (w1_in_ready),
        .a         (w1_a),
        .b         (w1_b),
        .carry_in  (w1_carry_in),
        .out_valid (w1_out_valid),
        .out_ready (w1_out_ready),
        .sum       (w1_sum),
        .carry_out (w1_carry_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation to the 8-bit instance, then count edges until out_valid (bounded).
    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          output int lat);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        carry_in = cv;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        total++;
        if (sum !== 8'h00 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_result: sum=%h cout=%b, want 00 0", sum, carry_out);
        end
        total++;
        if (w1_in_ready !== 1'b1 || w1_out_valid !== 1'b0 || w1_sum !== 1'b0) begin
            bad++;
            $display("FAIL reset_w1: in_ready=%b out_valid=%b sum=%b, want 1 0 0",
                     w1_in_ready, w1_out_valid, w1_sum);
        end
    endtask

    task automatic test_basic();
        int lat;
        run_op(8'h3C, 8'h05, 1'b0, lat);
        total++;
        if (lat !== 8) begin
            bad++;
            $display("FAIL basic_latency: got %0d edges, want 8", lat);
        end
        total++;
        if (sum !== 8'h41 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL basic_sum: sum=%h cout=%b, want 41 0", sum, carry_out);
        end
        drain();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h41) begin
            bad++;
            $display("FAIL basic_after_take: out_valid=%b in_ready=%b sum=%h, want 0 1 41",
                     out_valid, in_ready, sum);
        end
    endtask

    task automatic test_overflow();
        int lat;
        run_op(8'hFF, 8'h01, 1'b0, lat);
        total++;
        if (lat !== 8 || sum !== 8'h00 || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL wrap_ff_01: lat=%0d sum=%h cout=%b, want 8 00 1", lat, sum, carry_out);
        end
        drain();
        run_op(8'hFF, 8'hFF, 1'b1, lat);
        total++;
        if (lat !== 8 || sum !== 8'hFF || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL wrap_ff_ff_c: lat=%0d sum=%h cout=%b, want 8 ff 1", lat, sum, carry_out);
        end
        drain();
        run_op(8'hA5, 8'h5A, 1'b1, lat);
        total++;
        if (sum !== 8'h00 || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL wrap_a5_5a_c: sum=%h cout=%b, want 00 1", sum, carry_out);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        int late_valid;
        run_op(8'h12, 8'h34, 1'b0, lat);
        total++;
        if (sum !== 8'h46 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL bp_initial: sum=%h cout=%b, want 46 0", sum, carry_out);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            a        = 8'h11;
            b        = 8'h22;
            carry_in = 1'b1;
            tick();
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h46 || carry_out !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b sum=%h cout=%b, want 1 0 46 0",
                         i, out_valid, in_ready, sum, carry_out);
            end
        end
        in_valid = 1'b0;
        drain();
        late_valid = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) late_valid++;
            tick();
        end
        total++;
        if (late_valid !== 0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_no_second_op: out_valid cycles=%0d in_ready=%b, want 0 1",
                     late_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        in_valid = 1'b1;
        a        = 8'h55;
        b        = 8'hAA;
        carry_in = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 8'h00 || carry_out !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_run: in_ready=%b out_valid=%b sum=%h cout=%b, want 1 0 00 0",
                     in_ready, out_valid, sum, carry_out);
        end
        run_op(8'h80, 8'h80, 1'b0, lat);
        total++;
        if (lat !== 8 || sum !== 8'h00 || carry_out !== 1'b1) begin
            bad++;
            $display("FAIL rst_then_op: lat=%0d sum=%h cout=%b, want 8 00 1", lat, sum, carry_out);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int acc_cyc[$];
        int pulses;
        int long_pulse;
        int wrong_sum;
        logic prev_ov;
        pulses     = 0;
        long_pulse = 0;
        wrong_sum  = 0;
        prev_ov    = 1'b0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        a          = 8'h01;
        b          = 8'h02;
        carry_in   = 1'b0;
        for (int i = 0; i < 36; i++) begin
            if (in_ready) acc_cyc.push_back(i);
            if (out_valid) begin
                if (prev_ov) long_pulse++;
                else pulses++;
                if (sum !== 8'h03) wrong_sum++;
            end
            prev_ov = out_valid;
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        out_ready = 1'b0;
        total++;
        if (acc_cyc.size() !== 4) begin
            bad++;
            $display("FAIL b2b_accept_count: got %0d, want 4", acc_cyc.size());
        end else begin
            for (int k = 1; k < 4; k++) begin
                total++;
                if (acc_cyc[k] - acc_cyc[k-1] !== 10) begin
                    bad++;
                    $display("FAIL b2b_spacing[%0d]: got %0d cycles, want 10",
                             k, acc_cyc[k] - acc_cyc[k-1]);
                end
            end
        end
        total++;
        if (pulses !== 3 || long_pulse !== 0 || wrong_sum !== 0) begin
            bad++;
            $display("FAIL b2b_out_pulses: pulses=%0d extra=%0d badsum=%0d, want 3 0 0",
                     pulses, long_pulse, wrong_sum);
        end
    endtask

    task automatic test_width1();
        w1_in_valid = 1'b1;
        w1_a        = 1'b1;
        w1_b        = 1'b1;
        w1_carry_in = 1'b1;
        tick();
        w1_in_valid = 1'b0;
        total++;
        if (w1_out_valid !== 1'b0 || w1_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL w1_run: out_valid=%b in_ready=%b, want 0 0", w1_out_valid, w1_in_ready);
        end
        tick();
        total++;
        if (w1_out_valid !== 1'b1 || w1_sum !== 1'b1 || w1_carry_out !== 1'b1) begin
            bad++;
            $display("FAIL w1_result: out_valid=%b sum=%b cout=%b, want 1 1 1",
                     w1_out_valid, w1_sum, w1_carry_out);
        end
        w1_out_ready = 1'b1;
        tick();
        w1_out_ready = 1'b0;
        total++;
        if (w1_out_valid !== 1'b0 || w1_in_ready !== 1'b1 || w1_sum !== 1'b1) begin
            bad++;
            $display("FAIL w1_after_take: out_valid=%b in_ready=%b sum=%b, want 0 1 1",
                     w1_out_valid, w1_in_ready, w1_sum);
        end
    endtask

    initial begin
        rst          = 1'b1;
        in_valid     = 1'b0;
        a            = '0;
        b            = '0;
        carry_in     = 1'b0;
        out_ready    = 1'b0;
        w1_in_valid  = 1'b0;
        w1_a         = '0;
        w1_b         = '0;
        w1_carry_in  = 1'b0;
        w1_out_ready = 1'b0;

        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_width1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand and sum width in bits; legal range 1..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operands a, b and carry_in are valid this cycle.
REQ-005 in_ready  output  1  the block accepts a new operation this cycle.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 carry_in  input  1  carry into bit 0.
REQ-009 out_valid  output  1  sum and carry_out are valid.
REQ-010 out_ready  input  1  the consumer takes the result this cycle.
REQ-011 sum  output  WIDTH  (a + b + carry_in) mod 2^WIDTH.
REQ-012 carry_out  output  1  bit WIDTH of a + b + carry_in.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE; IDLE is the reset state.
REQ-014 IDLE: in_ready=1 and out_valid=0; on in_valid&in_ready the block SHALL latch a and b into shift registers, load the carry register with carry_in, clear the bit counter and go to RUN.
REQ-015 RUN: each cycle the block SHALL add a_sh[0], b_sh[0] and carry_reg with one full adder, then do all of the following on the same edge:
  - shift the sum bit into sum_sh at the MSB, shifting right;
  - shift a_sh and b_sh right by one;
  - load carry_reg from the adder carry;
  - increment the counter.
REQ-016 After exactly WIDTH RUN cycles the block SHALL enter DONE; the counter width is $clog2(WIDTH+1).
REQ-017 DONE: out_valid=1, with sum=sum_sh and carry_out=carry_reg; both SHALL stay stable until out_valid&out_ready.
REQ-018 On out_valid&out_ready the block SHALL go to IDLE on the next edge, and sum and carry_out SHALL keep their last values.
REQ-019 Latency: if an operation is accepted on edge T, out_valid SHALL rise after edge T+WIDTH.
REQ-020 Throughput: at most one operation per WIDTH+2 cycles when out_ready is held high.
REQ-021 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored and SHALL NOT disturb the operands.
REQ-022 If out_ready is held low, the block SHALL stay in DONE indefinitely, with no loss or change of result.
REQ-023 WIDTH=1 SHALL work: one RUN cycle, then DONE.
REQ-024 Overflow SHALL wrap modulo 2^WIDTH, and the lost bit SHALL appear only on carry_out.
REQ-025 No combinational path SHALL exist from in_valid or out_ready to in_ready or out_valid.

Reset
REQ-026 When rst=1 at a rising edge, the block SHALL set the state to IDLE and clear all of the following to 0: sum_sh, a_sh, b_sh, carry_reg, counter, out_valid, sum and carry_out.
REQ-027 Reset SHALL take priority over every handshake, and reset in RUN or DONE SHALL abandon the operation without producing an output.
REQ-028 In the first cycle after rst deasserts, in_ready SHALL be 1.

Structure
REQ-029 The state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in a shared package, serial_adder_pkg, together with the WIDTH default constant.
REQ-030 The block SHALL instantiate exactly one full_adder sub-module (ports a, b, carry_in, sum, carry_out) for the per-bit add; no other arithmetic operators SHALL be used on operand data.

Verification (WIDTH=8 unless stated)
REQ-031 a=8'h3C, b=8'h05, carry_in=0 accepted at edge T -> out_valid high after edge T+8, sum=8'h41, carry_out=0.
REQ-032 a=8'hFF, b=8'h01, carry_in=0 -> sum=8'h00, carry_out=1; a=8'hFF, b=8'hFF, carry_in=1 -> sum=8'hFF, carry_out=1.
REQ-033 Backpressure: out_ready low for 5 cycles in DONE, and in_valid pulsed with a=8'h11 during those cycles -> the required response is:
  - out_valid stays 1;
  - sum and carry_out are unchanged;
  - in_ready stays 0;
  - the second operation is not accepted.
REQ-034 rst asserted for 1 cycle during the 3rd RUN cycle -> next cycle in_ready=1, out_valid=0, sum=0, carry_out=0; a following operation 8'h80+8'h80 -> sum=8'h00, carry_out=1.
REQ-035 Back-to-back operations with out_ready tied high -> acceptances exactly WIDTH+2 cycles apart, out_valid high for exactly 1 cycle each.
REQ-036 WIDTH=1 instance: a=1, b=1, carry_in=1 -> after edge T+1, out_valid=1, sum=1, carry_out=1.
